// File: rtl/key_expansion.sv
// key_expansion: iterative AES-128 key schedule, one round key per clock, with an 11-entry round-key store
module key_expansion #(
  parameter int KEY_WIDTH  = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] cipher_key,
  output logic [KEY_WIDTH-1:0] round_key,
  output logic [3:0]           round_idx,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 keys_ready,
  input  logic [3:0]           rd_idx,
  output logic [KEY_WIDTH-1:0] rd_key
);
  typedef enum logic {IDLE, EXPAND} state_t;

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] rk_q, rk_d, nxt_key;
  logic [3:0]           idx_q, idx_d, nxt_idx;
  logic                 ready_q, ready_d;
  logic [KEY_WIDTH-1:0] store_q [0:NUM_ROUNDS];
  logic [KEY_WIDTH-1:0] store_d [0:NUM_ROUNDS];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the FIPS-197 affine map
  function automatic logic [7:0] sub_byte(input logic [7:0] a);
    logic [7:0] p, v;
    p = a;
    for (int i = 0; i < 6; i++) p = gf_mul(gf_mul(p, p), a);
    v = gf_mul(p, p);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < 10; i++) c = (4'(i) < r) ? xtime(c) : c;
    return c;
  endfunction

  // Next round key from the current one; round_key doubles as the working register W
  always_comb begin
    logic [31:0] t, n0, n1, n2, n3;
    nxt_idx = idx_q + 4'd1;
    t       = sub_word({rk_q[23:0], rk_q[31:24]}) ^ {rcon(nxt_idx), 24'h0};
    n0      = rk_q[127:96] ^ t;
    n1      = rk_q[95:64] ^ n0;
    n2      = rk_q[63:32] ^ n1;
    n3      = rk_q[31:0] ^ n2;
    nxt_key = {n0, n1, n2, n3};
  end

  // FSM next state: start loads key 0, each EXPAND cycle produces the next key until round 10
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    store_d = store_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d    = EXPAND;
        rk_d       = cipher_key;
        idx_d      = 4'd0;
        ready_d    = 1'b0;
        store_d[0] = cipher_key;
      end
    end else if (idx_q == 4'(NUM_ROUNDS)) begin
      state_d = IDLE;
      ready_d = 1'b1;
    end else begin
      rk_d             = nxt_key;
      idx_d            = nxt_idx;
      store_d[nxt_idx] = nxt_key;
    end
  end

  // State, streamed key and store registers; reset wipes everything so no partial schedule survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rk_q    <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) store_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      store_q <= store_d;
    end
  end

  assign busy       = (state_q == EXPAND);
  assign key_valid  = busy;
  assign done       = busy && (idx_q == 4'(NUM_ROUNDS));
  assign round_key  = rk_q;
  assign round_idx  = idx_q;
  assign keys_ready = ready_q;
  assign rd_key     = (ready_q && rd_idx <= 4'(NUM_ROUNDS)) ? store_q[rd_idx] : '0;
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: self-checking bench for key_expansion against a word-array AES-128 key schedule model
module tb_key_expansion;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] cipher_key = '0;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid, busy, done, keys_ready;
  logic [3:0]   rd_idx = '0;
  logic [127:0] rd_key;

  int checks = 0;
  int errors = 0;

  key_expansion dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cipher_key(cipher_key),
    .round_key(round_key), .round_idx(round_idx), .key_valid(key_valid),
    .busy(busy), .done(done), .keys_ready(keys_ready),
    .rd_idx(rd_idx), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] k1;
    logic [127:0] k10;
  } vec_t;

  vec_t         vecs [2];
  logic [7:0]   sbox [256];
  logic [7:0]   alog [256];
  int           lg   [256];
  logic [7:0]   rcon_tab [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] mk [0:10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box from log/antilog tables of generator 3, then the bitwise affine transform
  task automatic build_sbox();
    logic [7:0] e, inv, s;
    logic [7:0] c;
    c = 8'h63;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      alog[i] = e;
      lg[e] = i;
      e = e ^ {e[6:0], 1'b0} ^ (e[7] ? 8'h1b : 8'h00);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : alog[(255 - lg[x]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8] ^ inv[(b + 7) % 8] ^ c[b];
      sbox[x] = s;
    end
  endtask

  // FIPS-197 KeyExpansion over 44 words, regrouped into 11 round keys
  task automatic model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon_tab[i / 4], 24'h0};
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= 10; r++) mk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // Starts an expansion of key (call near a negedge) and checks every streamed cycle plus the
  // first idle cycle; optionally pulses start with another key while the round index is pulse_r
  task automatic expand_and_check(input logic [127:0] key, input int pulse_r, input logic [127:0] pulse_key);
    model(key);
    cipher_key = key;
    start = 1'b1;
    for (int r = 0; r <= 10; r++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("valid r%0d", r), key_valid, 1);
      chk($sformatf("busy r%0d", r), busy, 1);
      chk($sformatf("idx r%0d", r), round_idx, r);
      chk($sformatf("key r%0d", r), round_key, mk[r]);
      chk($sformatf("done r%0d", r), done, r == 10);
      chk($sformatf("ready r%0d", r), keys_ready, 0);
      if (r == pulse_r) begin
        start = 1'b1;
        cipher_key = pulse_key;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("valid end", key_valid, 0);
    chk("busy end", busy, 0);
    chk("done end", done, 0);
    chk("ready end", keys_ready, 1);
    chk("key hold", round_key, mk[10]);
    chk("idx hold", round_idx, 10);
  endtask

  task automatic readback();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_idx = 4'(i);
      #1;
      chk($sformatf("rd_key %0d", i), rd_key, i <= 10 ? mk[i] : 128'h0);
    end
  endtask

  initial begin
    logic [127:0] k, k2;
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h0, 128'h62636363626363636263636362636363, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    build_sbox();

    repeat (3) @(negedge clk);
    chk("reset round_key", round_key, 0);
    chk("reset round_idx", round_idx, 0);
    chk("reset key_valid", key_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset keys_ready", keys_ready, 0);
    chk("reset rd_key", rd_key, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer vectors: stream, store and the published round keys 1 and 10
    foreach (vecs[v]) begin
      expand_and_check(vecs[v].key, -1, 0);
      readback();
      @(negedge clk);
      rd_idx = 4'd1;
      #1 chk($sformatf("kat%0d idx1", v), rd_key, vecs[v].k1);
      rd_idx = 4'd10;
      #1 chk($sformatf("kat%0d idx10", v), rd_key, vecs[v].k10);
      rd_idx = 4'd11;
      #1 chk($sformatf("kat%0d idx11", v), rd_key, 0);
    end

    // start pulsed mid-expansion and on the final round is ignored; back-to-back start is accepted
    k2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    expand_and_check(vecs[0].key, 4, k2);
    readback();
    @(negedge clk);
    expand_and_check(vecs[0].key, 10, k2);
    expand_and_check(k2, -1, 0);
    readback();

    // Random keys against the model
    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      expand_and_check(k, -1, 0);
      readback();
    end

    // Reset asserted while round 6 is on the outputs
    k = {$urandom, $urandom, $urandom, $urandom};
    model(k);
    @(negedge clk);
    cipher_key = k;
    start = 1'b1;
    repeat (7) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre-reset idx", round_idx, 6);
    chk("pre-reset key", round_key, mk[6]);
    rd_idx = 4'd0;
    rst_n = 1'b0;
    #1;
    chk("abort round_key", round_key, 0);
    chk("abort round_idx", round_idx, 0);
    chk("abort key_valid", key_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort keys_ready", keys_ready, 0);
    chk("abort rd_key", rd_key, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expand_and_check(k, -1, 0);
    readback();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
